alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Adds XOR/NOR/SLT/SLTU, and an iterative multiply/divide unit with HI/LO registers in the MIPS style (MULT/MULTU/DIV/DIVU/MFHI/MFLO).
- Sits in the EX stage. Uses a valid/ready handshake so the pipeline control can stall while a multi-cycle op is in progress.

---
 rtl/alu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with an optional iterative multiply/divide
// unit (HI/LO registers, MIPS-style MULT/MULTU/DIV/DIVU/MFHI/MFLO).
// Optional feature macro: ALU_SEQ_MULDIV_EN (undefined: mul/div opcodes act
// as unsupported single-cycle ops, hi=lo=0, busy=0, in_ready=1).
module alu_seq #(
  parameter int W    = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    result,
  output logic            ov,
  output logic            out_valid,
  output logic [W-1:0]    hi,
  output logic [W-1:0]    lo,
  output logic            busy
);

  localparam logic [OP_W-1:0] OP_AND   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(13);

  // Single-cycle ALU; returns {ov, result}. MFHI/MFLO read the live HI/LO.
  function automatic logic [W:0] sc_alu(input logic [OP_W-1:0] f_op,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic [W-1:0] hv,
                                        input logic [W-1:0] lv);
    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic [W-1:0] s;
    logic [W-1:0] d;
    xs = x;
    ys = y;
    s  = x + y;
    d  = x - y;
    case (f_op)
      OP_AND:  sc_alu = {1'b0, x & y};
      OP_OR:   sc_alu = {1'b0, x | y};
      OP_ADD:  sc_alu = {(x[W-1] == y[W-1]) && (s[W-1] != x[W-1]), s};
      OP_XOR:  sc_alu = {1'b0, x ^ y};
      OP_NOR:  sc_alu = {1'b0, ~(x | y)};
      OP_SLTU: sc_alu = {1'b0, {(W-1){1'b0}}, x < y};
      OP_SUB:  sc_alu = {(x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), d};
      OP_SLT:  sc_alu = {1'b0, {(W-1){1'b0}}, xs < ys};
      OP_MFHI: sc_alu = {1'b0, hv};
      OP_MFLO: sc_alu = {1'b0, lv};
      default: sc_alu = '0;
    endcase
  endfunction

  // Conditional two's-complement negate (magnitude <-> signed value).
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic neg);
    mag = neg ? -x : x;
  endfunction

  logic [W:0]   sc_out;
  logic         xfer;
  logic         is_md;
  logic         fix_now;
  logic [W-1:0] fix_hi;
  logic [W-1:0] fix_lo;
  logic         fix_ov;
  logic [W-1:0] hi_cur;
  logic [W-1:0] lo_cur;

  assign xfer   = in_valid & in_ready;
  assign sc_out = sc_alu(op, a, b, hi_cur, lo_cur);

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [W:0]         rem_r;
  logic [W-1:0]       q_r;
  logic [W-1:0]       m_r;
  logic               sa_r, sb_r, is_div_r, dz_r, fault_r;
  logic [W-1:0]       hi_r, lo_r;
  logic               is_mul, is_div, sgn_op;
  logic [W:0]         mul_sum;
  logic [W:0]         div_sh;
  logic [W:0]         div_diff;
  logic [2*W-1:0]     prod;

  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign sgn_op  = (op == OP_MULT) || (op == OP_DIV);
  assign is_md   = is_mul || is_div;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign fix_now  = (state == FIX);
  assign hi_cur   = hi_r;
  assign lo_cur   = lo_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: launch on a mul/div transfer, FIX after the last iteration.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (xfer && is_mul) state_nx = MUL;
            else if (xfer && is_div) state_nx = DIV;
      MUL,
      DIV:  if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mul_sum  = rem_r + (q_r[0] ? {1'b0, m_r} : '0);
  assign div_sh   = {rem_r[W-1:0], q_r[W-1]};
  assign div_diff = div_sh - {1'b0, m_r};

  // Sign correction of the unsigned iteration result.
  always_comb begin
    prod = {rem_r[W-1:0], q_r};
    if (sa_r ^ sb_r) prod = -prod;
    fix_ov = fault_r;
    if (is_div_r) begin
      fix_hi = mag(rem_r[W-1:0], sa_r);
      fix_lo = dz_r ? '1 : mag(q_r, sa_r ^ sb_r);
    end else begin
      fix_hi = prod[2*W-1:W];
      fix_lo = prod[W-1:0];
    end
  end

  // Iteration datapath: operand latch on entry, shift-add or restoring step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && xfer && is_md) begin
      cnt      <= CNT_W'(W);
      sa_r     <= sgn_op & a[W-1];
      sb_r     <= sgn_op & b[W-1];
      q_r      <= mag(a, sgn_op & a[W-1]);
      m_r      <= mag(b, sgn_op & b[W-1]);
      rem_r    <= '0;
      is_div_r <= is_div;
      dz_r     <= is_div && (b == '0);
      fault_r  <= is_div && ((b == '0) ||
                  (sgn_op && a == {1'b1, {(W-1){1'b0}}} && b == '1));
    end else if (state == MUL) begin
      cnt   <= cnt - CNT_W'(1);
      rem_r <= {1'b0, mul_sum[W:1]};
      q_r   <= {mul_sum[0], q_r[W-1:1]};
    end else if (state == DIV) begin
      cnt <= cnt - CNT_W'(1);
      if (!div_diff[W]) begin
        rem_r <= div_diff;
        q_r   <= {q_r[W-2:0], 1'b1};
      end else begin
        rem_r <= div_sh;
        q_r   <= {q_r[W-2:0], 1'b0};
      end
    end
  end

  // HI/LO are written only when a mul/div completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (fix_now) begin
      hi_r <= fix_hi;
      lo_r <= fix_lo;
    end
  end
`else
  assign is_md    = 1'b0;
  assign fix_now  = 1'b0;
  assign fix_hi   = '0;
  assign fix_lo   = '0;
  assign fix_ov   = 1'b0;
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
  assign hi_cur   = '0;
  assign lo_cur   = '0;
  assign hi       = '0;
  assign lo       = '0;
`endif

  // Output register: single-cycle result on transfer, mul/div result at FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (xfer && !is_md) begin
        result    <= sc_out[W-1:0];
        ov        <= sc_out[W];
        out_valid <= 1'b1;
      end else if (fix_now) begin
        result    <= fix_lo;
        ov        <= fix_ov;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed cases, stall, abort, random.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, result, hi, lo;
  logic [3:0]   op;
  logic         in_valid, in_ready, ov, out_valid, busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_seq #(.W(W), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .ov(ov), .out_valid(out_valid),
    .hi(hi), .lo(lo), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic rules (integer math, C-style divide).
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, y,
                                input logic [W-1:0] hin, lin,
                                output logic [W-1:0] r, output logic eo,
                                output logic [W-1:0] ho, lo_o, output logic multi);
    int sa, sb, ua, ub, s, p, q, rm;
    sa = $signed(x); sb = $signed(y); ua = x; ub = y;
    r = '0; eo = 1'b0; ho = hin; lo_o = lin; multi = 1'b0;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin s = sa + sb; r = s[W-1:0]; eo = (s > 127) || (s < -128); end
      4'd3: r = x ^ y;
      4'd4: r = ~(x | y);
      4'd5: r = (ua < ub) ? 8'd1 : 8'd0;
      4'd6: begin s = sa - sb; r = s[W-1:0]; eo = (s > 127) || (s < -128); end
      4'd7: r = (sa < sb) ? 8'd1 : 8'd0;
      4'd8, 4'd9: if (MD) begin
        p = (o == 4'd8) ? sa * sb : ua * ub;
        ho = p[15:8]; lo_o = p[7:0]; r = lo_o; multi = 1'b1;
      end
      4'd10, 4'd11: if (MD) begin
        multi = 1'b1;
        if (y == 0) begin
          ho = x; lo_o = 8'hFF; eo = 1'b1;
        end else if (o == 4'd10 && sa == -128 && sb == -1) begin
          ho = 8'h00; lo_o = 8'h80; eo = 1'b1;
        end else begin
          q  = (o == 4'd10) ? sa / sb : ua / ub;
          rm = (o == 4'd10) ? sa % sb : ua % ub;
          ho = rm[W-1:0]; lo_o = q[W-1:0];
        end
        r = lo_o;
      end
      4'd12: if (MD) r = hin;
      4'd13: if (MD) r = lin;
      default: r = '0;
    endcase
  endfunction

  // Issue one op from a negedge; check timing and outputs against the model.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] er, eh, el;
    logic eo, em;
    model(o, x, y, m_hi, m_lo, er, eo, eh, el, em);
    op = o; a = x; b = y; in_valid = 1'b1;
    chk($sformatf("ready op%0d", o), in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (em) begin
      for (int k = 1; k <= W + 1; k++) begin
        chk($sformatf("busy op%0d c%0d", o, k), busy, 1);
        chk($sformatf("in_ready_low op%0d c%0d", o, k), in_ready, 0);
        chk($sformatf("early_valid op%0d c%0d", o, k), out_valid, 0);
        @(negedge clk);
      end
    end
    chk($sformatf("out_valid op%0d", o), out_valid, 1);
    chk($sformatf("result op%0d a=%0h b=%0h", o, x, y), result, er);
    chk($sformatf("ov op%0d a=%0h b=%0h", o, x, y), ov, eo);
    chk($sformatf("hi op%0d", o), hi, eh);
    chk($sformatf("lo op%0d", o), lo, el);
    chk($sformatf("in_ready_after op%0d", o), in_ready, 1);
    m_hi = eh; m_lo = el;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " result"}, result, 0);
    chk({tag, " ov"}, ov, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " hi"}, hi, 0);
    chk({tag, " lo"}, lo, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] er, eh, el;
    logic eo, em;
    int waited, pulses;
    logic [3:0] ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Directed cases
    run_op(4'd2, 8'h7F, 8'h01);
    run_op(4'd6, 8'h80, 8'h01);
    run_op(4'd7, 8'hFF, 8'h01);
    run_op(4'd5, 8'hFF, 8'h01);
    run_op(4'd4, 8'h0F, 8'hF0);
    run_op(4'd3, 8'hAA, 8'hFF);
    run_op(4'd8, 8'hFD, 8'h05);
    @(negedge clk);
    chk("out_valid_one_pulse", out_valid, 0);
    run_op(4'd9, 8'hFF, 8'hFF);
    run_op(4'd11, 8'd100, 8'd7);
    run_op(4'd10, 8'hF9, 8'h02);
    run_op(4'd10, 8'h80, 8'hFF);
    run_op(4'd11, 8'h05, 8'h00);
    run_op(4'd12, 8'h00, 8'h00);
    run_op(4'd13, 8'h00, 8'h00);
    run_op(4'd14, 8'h12, 8'h34);
    run_op(4'd15, 8'hFF, 8'hFF);
    run_op(4'd0, 8'hC3, 8'h5A);
    run_op(4'd1, 8'hC3, 8'h5A);

    // Stall: ADD held high while MULT runs
    model(4'd8, 8'hFD, 8'h05, m_hi, m_lo, er, eo, eh, el, em);
    m_hi = eh; m_lo = el;
    op = 4'd8; a = 8'hFD; b = 8'h05; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 4'd2; a = 8'h11; b = 8'h22;
    waited = 1;
    while (!in_ready && waited < 4 * W) begin
      @(negedge clk);
      waited++;
    end
    chk("stall_wait_cycles", waited, MD ? W + 2 : 1);
    chk("stall_mult_hi", hi, eh);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_add_valid", out_valid, 1);
    chk("stall_add_result", result, 8'h33);
    chk("stall_add_ov", ov, 0);
    run_op(4'd12, 8'h00, 8'h00);

    // Reset 4 cycles into a DIV
    op = 4'd10; a = 8'h64; b = 8'h07; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("abort");
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("no_pulse_after_abort", pulses, 0);

    // Random
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
